adbg_axi_mem_slave: RTL and testbench

// AXI4 slave scratchpad that is the responder to the debug unit's AXI4 master port, used as the debug-visible memory target in bring-up and sim fabrics.

---
 rtl/adbg_axi_mem_slave.sv | 245 ++++++++++++++++++++++++
 tb/tb_adbg_axi_mem_slave.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adbg_axi_mem_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : adbg_axi_mem_slave                                           |
// | Description : AXI4 slave scratchpad answering the debug unit's AXI master. |
// |               Single outstanding transaction, FIXED/INCR bursts served     |
// |               from an internal flop-array memory; WRAP, reserved bursts    |
// |               and oversize beats complete with SLVERR and no side effects. |
// | Ports       : axi_aclk/axi_aresetn  clock, async active-low reset          |
// |               axi_slave_aw_* / w_* / b_*   write address/data/response     |
// |               axi_slave_ar_* / r_*         read address/data               |
// |               prot/region/lock/cache/qos/user inputs are ignored; user     |
// |               outputs are driven 0.                                        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module adbg_axi_mem_slave #(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int AXI_USER_WIDTH = 6,
   parameter int AXI_ID_WIDTH   = 3,
   parameter int MEM_WORDS      = 256
) (
   input  logic                        axi_aclk,
   input  logic                        axi_aresetn,
   // write address
   input  logic                        axi_slave_aw_valid,
   output logic                        axi_slave_aw_ready,
   input  logic [AXI_ADDR_WIDTH-1:0]   axi_slave_aw_addr,
   input  logic [7:0]                  axi_slave_aw_len,
   input  logic [2:0]                  axi_slave_aw_size,
   input  logic [1:0]                  axi_slave_aw_burst,
   input  logic [AXI_ID_WIDTH-1:0]     axi_slave_aw_id,
   input  logic [2:0]                  axi_slave_aw_prot,
   input  logic [3:0]                  axi_slave_aw_region,
   input  logic                        axi_slave_aw_lock,
   input  logic [3:0]                  axi_slave_aw_cache,
   input  logic [3:0]                  axi_slave_aw_qos,
   input  logic [AXI_USER_WIDTH-1:0]   axi_slave_aw_user,
   // write data
   input  logic                        axi_slave_w_valid,
   output logic                        axi_slave_w_ready,
   input  logic [AXI_DATA_WIDTH-1:0]   axi_slave_w_data,
   input  logic [AXI_DATA_WIDTH/8-1:0] axi_slave_w_strb,
   input  logic                        axi_slave_w_last,
   input  logic [AXI_USER_WIDTH-1:0]   axi_slave_w_user,
   // write response
   output logic                        axi_slave_b_valid,
   input  logic                        axi_slave_b_ready,
   output logic [1:0]                  axi_slave_b_resp,
   output logic [AXI_ID_WIDTH-1:0]     axi_slave_b_id,
   output logic [AXI_USER_WIDTH-1:0]   axi_slave_b_user,
   // read address
   input  logic                        axi_slave_ar_valid,
   output logic                        axi_slave_ar_ready,
   input  logic [AXI_ADDR_WIDTH-1:0]   axi_slave_ar_addr,
   input  logic [7:0]                  axi_slave_ar_len,
   input  logic [2:0]                  axi_slave_ar_size,
   input  logic [1:0]                  axi_slave_ar_burst,
   input  logic [AXI_ID_WIDTH-1:0]     axi_slave_ar_id,
   input  logic [2:0]                  axi_slave_ar_prot,
   input  logic [3:0]                  axi_slave_ar_region,
   input  logic                        axi_slave_ar_lock,
   input  logic [3:0]                  axi_slave_ar_cache,
   input  logic [3:0]                  axi_slave_ar_qos,
   input  logic [AXI_USER_WIDTH-1:0]   axi_slave_ar_user,
   // read data
   output logic                        axi_slave_r_valid,
   input  logic                        axi_slave_r_ready,
   output logic [AXI_DATA_WIDTH-1:0]   axi_slave_r_data,
   output logic [1:0]                  axi_slave_r_resp,
   output logic                        axi_slave_r_last,
   output logic [AXI_ID_WIDTH-1:0]     axi_slave_r_id,
   output logic [AXI_USER_WIDTH-1:0]   axi_slave_r_user
);

   localparam int STRB_W = AXI_DATA_WIDTH / 8;
   localparam int OFF_W  = $clog2(STRB_W);
   localparam int IDX_W  = $clog2(MEM_WORDS);
   localparam logic [AXI_ADDR_WIDTH-1:0] MEM_WORDS_A = AXI_ADDR_WIDTH'(MEM_WORDS);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WDATA = 2'd1;
   localparam logic [1:0] ST_WRESP = 2'd2;
   localparam logic [1:0] ST_RDATA = 2'd3;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic       GRANT_WRITE = 1'b0;
   localparam logic       GRANT_READ  = 1'b1;

   logic [1:0]                state_q, state_d;
   logic                      last_grant_q, last_grant_d;
   logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [7:0]                len_q, len_d;
   logic [2:0]                size_q, size_d;
   logic [1:0]                burst_q, burst_d;
   logic [AXI_ID_WIDTH-1:0]   id_q, id_d;
   logic [7:0]                cnt_q, cnt_d;
   logic                      err_q, err_d;

   logic [AXI_DATA_WIDTH-1:0] mem_q [MEM_WORDS];

   logic                      beat_oor;
   logic [IDX_W-1:0]          beat_idx;
   logic                      beat_last;
   logic [AXI_ADDR_WIDTH-1:0] next_addr;
   logic                      beat_bad;
   logic                      mem_we;
   logic                      aw_hs;
   logic                      ar_hs;

   // Sideband inputs carry nothing this target needs.
   logic unused_sidebands;
   assign unused_sidebands = ^{axi_slave_aw_prot, axi_slave_aw_region, axi_slave_aw_lock,
                               axi_slave_aw_cache, axi_slave_aw_qos, axi_slave_aw_user,
                               axi_slave_ar_prot, axi_slave_ar_region, axi_slave_ar_lock,
                               axi_slave_ar_cache, axi_slave_ar_qos, axi_slave_ar_user,
                               axi_slave_w_user};

   assign beat_oor  = (addr_q >> OFF_W) >= MEM_WORDS_A;
   assign beat_idx  = addr_q[OFF_W +: IDX_W];
   assign beat_last = (cnt_q == len_q);
   // FIXED keeps the address; error bursts never touch memory so their
   // address progression does not matter.
   assign next_addr = (burst_q == BURST_INCR) ? addr_q + (AXI_ADDR_WIDTH'(1) << size_q) : addr_q;

   // Write wins a tie only when the previous grant went to a read.
   assign axi_slave_aw_ready = (state_q == ST_IDLE) & axi_slave_aw_valid &
                               (~axi_slave_ar_valid | (last_grant_q == GRANT_READ));
   assign axi_slave_ar_ready = (state_q == ST_IDLE) & axi_slave_ar_valid & ~axi_slave_aw_ready;
   assign aw_hs = axi_slave_aw_ready;
   assign ar_hs = axi_slave_ar_ready;

   // A beat with a bad address or a misplaced w_last is itself dropped and
   // poisons the rest of the burst.
   assign beat_bad = beat_oor | (axi_slave_w_last != beat_last);

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      addr_d       = addr_q;
      len_d        = len_q;
      size_d       = size_q;
      burst_d      = burst_q;
      id_d         = id_q;
      cnt_d        = cnt_q;
      err_d        = err_q;
      mem_we       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (aw_hs) begin
               state_d      = ST_WDATA;
               last_grant_d = GRANT_WRITE;
               addr_d       = axi_slave_aw_addr;
               len_d        = axi_slave_aw_len;
               size_d       = axi_slave_aw_size;
               burst_d      = axi_slave_aw_burst;
               id_d         = axi_slave_aw_id;
               cnt_d        = 8'd0;
               err_d        = axi_slave_aw_burst[1] | (axi_slave_aw_size > 3'(OFF_W));
            end else if (ar_hs) begin
               state_d      = ST_RDATA;
               last_grant_d = GRANT_READ;
               addr_d       = axi_slave_ar_addr;
               len_d        = axi_slave_ar_len;
               size_d       = axi_slave_ar_size;
               burst_d      = axi_slave_ar_burst;
               id_d         = axi_slave_ar_id;
               cnt_d        = 8'd0;
               err_d        = axi_slave_ar_burst[1] | (axi_slave_ar_size > 3'(OFF_W));
            end
         end
         ST_WDATA: begin
            if (axi_slave_w_valid) begin
               mem_we = ~err_q & ~beat_bad;
               err_d  = err_q | beat_bad;
               addr_d = next_addr;
               cnt_d  = cnt_q + 8'd1;
               if (beat_last) state_d = ST_WRESP;
            end
         end
         ST_WRESP: begin
            if (axi_slave_b_ready) state_d = ST_IDLE;
         end
         ST_RDATA: begin
            if (axi_slave_r_ready) begin
               addr_d = next_addr;
               cnt_d  = cnt_q + 8'd1;
               if (beat_last) state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         state_q      <= ST_IDLE;
         last_grant_q <= GRANT_READ;
         addr_q       <= '0;
         len_q        <= '0;
         size_q       <= '0;
         burst_q      <= '0;
         id_q         <= '0;
         cnt_q        <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         addr_q       <= addr_d;
         len_q        <= len_d;
         size_q       <= size_d;
         burst_q      <= burst_d;
         id_q         <= id_d;
         cnt_q        <= cnt_d;
         err_q        <= err_d;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge axi_aclk) begin
      if (mem_we) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (axi_slave_w_strb[b]) mem_q[beat_idx][8*b +: 8] <= axi_slave_w_data[8*b +: 8];
         end
      end
   end

   assign axi_slave_w_ready = (state_q == ST_WDATA);
   assign axi_slave_b_valid = (state_q == ST_WRESP);
   assign axi_slave_b_resp  = (axi_slave_b_valid & err_q) ? RESP_SLVERR : RESP_OKAY;
   assign axi_slave_b_id    = id_q;
   assign axi_slave_b_user  = '0;

   // Read beat outputs follow the registered beat address, so they stay put
   // while the master stalls.
   assign axi_slave_r_valid = (state_q == ST_RDATA);
   assign axi_slave_r_data  = (axi_slave_r_valid & ~err_q & ~beat_oor) ? mem_q[beat_idx] : '0;
   assign axi_slave_r_resp  = (axi_slave_r_valid & (err_q | beat_oor)) ? RESP_SLVERR : RESP_OKAY;
   assign axi_slave_r_last  = axi_slave_r_valid & beat_last;
   assign axi_slave_r_id    = id_q;
   assign axi_slave_r_user  = '0;

endmodule
`default_nettype wire

// File: tb/tb_adbg_axi_mem_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_adbg_axi_mem_slave                                        |
// | Description : Scoreboard bench for adbg_axi_mem_slave. Stimulus tasks      |
// |               update a byte-level memory model and queue expected B/R      |
// |               responses; negedge monitors compare what the DUT presents.   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_adbg_axi_mem_slave;

   localparam int TMO = 2000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        aw_valid = 0, aw_ready;
   logic [31:0] aw_addr = 0;
   logic [7:0]  aw_len = 0;
   logic [2:0]  aw_size = 0, aw_id = 0;
   logic [1:0]  aw_burst = 0;
   logic        w_valid = 0, w_ready, w_last = 0;
   logic [63:0] w_data = 0;
   logic [7:0]  w_strb = 0;
   logic        b_valid, b_ready = 0;
   logic [1:0]  b_resp;
   logic [2:0]  b_id;
   logic [5:0]  b_user, r_user;
   logic        ar_valid = 0, ar_ready;
   logic [31:0] ar_addr = 0;
   logic [7:0]  ar_len = 0;
   logic [2:0]  ar_size = 0, ar_id = 0;
   logic [1:0]  ar_burst = 0;
   logic        r_valid, r_ready = 0, r_last;
   logic [63:0] r_data;
   logic [1:0]  r_resp;
   logic [2:0]  r_id;

   always #5 clk = ~clk;

   adbg_axi_mem_slave dut (
      .axi_aclk(clk), .axi_aresetn(rst_n),
      .axi_slave_aw_valid(aw_valid), .axi_slave_aw_ready(aw_ready), .axi_slave_aw_addr(aw_addr),
      .axi_slave_aw_len(aw_len), .axi_slave_aw_size(aw_size), .axi_slave_aw_burst(aw_burst),
      .axi_slave_aw_id(aw_id), .axi_slave_aw_prot(3'd0), .axi_slave_aw_region(4'd0),
      .axi_slave_aw_lock(1'b0), .axi_slave_aw_cache(4'd0), .axi_slave_aw_qos(4'd0),
      .axi_slave_aw_user(6'd0),
      .axi_slave_w_valid(w_valid), .axi_slave_w_ready(w_ready), .axi_slave_w_data(w_data),
      .axi_slave_w_strb(w_strb), .axi_slave_w_last(w_last), .axi_slave_w_user(6'd0),
      .axi_slave_b_valid(b_valid), .axi_slave_b_ready(b_ready), .axi_slave_b_resp(b_resp),
      .axi_slave_b_id(b_id), .axi_slave_b_user(b_user),
      .axi_slave_ar_valid(ar_valid), .axi_slave_ar_ready(ar_ready), .axi_slave_ar_addr(ar_addr),
      .axi_slave_ar_len(ar_len), .axi_slave_ar_size(ar_size), .axi_slave_ar_burst(ar_burst),
      .axi_slave_ar_id(ar_id), .axi_slave_ar_prot(3'd0), .axi_slave_ar_region(4'd0),
      .axi_slave_ar_lock(1'b0), .axi_slave_ar_cache(4'd0), .axi_slave_ar_qos(4'd0),
      .axi_slave_ar_user(6'd0),
      .axi_slave_r_valid(r_valid), .axi_slave_r_ready(r_ready), .axi_slave_r_data(r_data),
      .axi_slave_r_resp(r_resp), .axi_slave_r_last(r_last), .axi_slave_r_id(r_id),
      .axi_slave_r_user(r_user)
   );

   typedef struct packed { logic [1:0] resp; logic [2:0] id; } b_exp_t;
   typedef struct packed { logic [63:0] data; logic [1:0] resp; logic last; logic [2:0] id; } r_exp_t;

   b_exp_t      b_q[$];
   r_exp_t      r_q[$];
   logic [63:0] model_mem [256];
   logic [63:0] wbuf [256];
   logic [7:0]  sbuf [256];
   int          checks = 0;
   int          errors = 0;
   bit          mon_en = 1;
   int          rr_mode = 0;   // 0: always ready, 1: random, 2: held low
   string       grant_log = "";
   b_exp_t      be_m;
   r_exp_t      re_m;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL timeout_%s: waited %0d cycles, required a handshake", name, TMO);
   endtask

   // ---------------- reference model ----------------
   function automatic void model_write(input logic [31:0] addr, input logic [7:0] len,
                                       input logic [2:0] size, input logic [1:0] burst,
                                       input logic [2:0] id, input int early);
      logic [31:0] a;
      bit          err;
      bit          oor;
      bit          bad;
      b_exp_t      be;
      a   = addr;
      err = (burst >= 2) || (size > 3);
      for (int i = 0; i <= int'(len); i++) begin
         oor = (a >> 3) >= 256;
         bad = oor || (((i == int'(len)) || (i == early)) != (i == int'(len)));
         if (!err && !bad)
            for (int b = 0; b < 8; b++)
               if (sbuf[i][b]) model_mem[a[10:3]][8*b +: 8] = wbuf[i][8*b +: 8];
         err = err || bad;
         if (burst == 2'd1) a = a + (32'd1 << size);
      end
      be.resp = err ? 2'd2 : 2'd0;
      be.id   = id;
      b_q.push_back(be);
   endfunction

   function automatic void model_read(input logic [31:0] addr, input logic [7:0] len,
                                      input logic [2:0] size, input logic [1:0] burst,
                                      input logic [2:0] id);
      logic [31:0] a;
      bit          err;
      bit          oor;
      r_exp_t      re;
      a   = addr;
      err = (burst >= 2) || (size > 3);
      for (int i = 0; i <= int'(len); i++) begin
         oor     = (a >> 3) >= 256;
         re.data = (err || oor) ? 64'd0 : model_mem[a[10:3]];
         re.resp = (err || oor) ? 2'd2 : 2'd0;
         re.last = (i == int'(len));
         re.id   = id;
         r_q.push_back(re);
         if (burst == 2'd1) a = a + (32'd1 << size);
      end
   endfunction

   // ---------------- stimulus ----------------
   task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [2:0] id, input int early,
                           input bit gaps);
      int n;
      model_write(addr, len, size, burst, id, early);
      aw_addr = addr; aw_len = len; aw_size = size; aw_burst = burst; aw_id = id; aw_valid = 1;
      n = 0;
      forever begin
         @(negedge clk);
         if (aw_ready) break;
         if (++n > TMO) begin timeout("aw"); break; end
      end
      @(posedge clk); #1;
      aw_valid = 0;
      for (int i = 0; i <= int'(len); i++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            w_valid = 0;
            repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
         end
         w_data = wbuf[i]; w_strb = sbuf[i];
         w_last = (i == int'(len)) || (i == early);
         w_valid = 1;
         n = 0;
         forever begin
            @(negedge clk);
            if (w_ready) break;
            if (++n > TMO) begin timeout("w"); break; end
         end
         @(posedge clk); #1;
      end
      w_valid = 0; w_last = 0;
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      b_ready = 1;
      n = 0;
      forever begin
         @(negedge clk);
         if (b_valid) break;
         if (++n > TMO) begin timeout("b"); break; end
      end
      @(posedge clk); #1;
      b_ready = 0;
   endtask

   task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [2:0] id);
      int n;
      model_read(addr, len, size, burst, id);
      ar_addr = addr; ar_len = len; ar_size = size; ar_burst = burst; ar_id = id; ar_valid = 1;
      n = 0;
      forever begin
         @(negedge clk);
         if (ar_ready) break;
         if (++n > TMO) begin timeout("ar"); break; end
      end
      @(posedge clk); #1;
      ar_valid = 0;
      n = 0;
      forever begin
         @(negedge clk);
         if (r_valid && r_ready && r_last) break;
         if (++n > TMO) begin timeout("r"); break; end
      end
      @(posedge clk); #1;
   endtask

   task automatic fill(input int beats, input logic [7:0] strb);
      for (int i = 0; i < beats; i++) begin
         wbuf[i] = {$urandom, $urandom};
         sbuf[i] = strb;
      end
   endtask

   // ---------------- r_ready driver ----------------
   initial forever begin
      @(posedge clk); #1;
      r_ready = (rr_mode == 0) ? 1'b1 : (rr_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b0;
   end

   // ---------------- monitors ----------------
   always @(negedge clk) begin
      if (rst_n) begin
         if (aw_ready || ar_ready) begin
            checks++;
            if (aw_ready && ar_ready) begin
               errors++;
               $display("FAIL grant_exclusive: aw_ready=1 ar_ready=1, required at most one");
            end
         end
         if (aw_valid && aw_ready) grant_log = {grant_log, "W"};
         if (ar_valid && ar_ready) grant_log = {grant_log, "R"};
         if (b_valid && b_ready) begin
            if (b_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL b_unexpected: got resp %0d id %0d, required no response", b_resp, b_id);
            end else begin
               be_m = b_q.pop_front();
               check("b_resp", 64'(b_resp), 64'(be_m.resp));
               check("b_id", 64'(b_id), 64'(be_m.id));
            end
         end
         if (mon_en && r_valid) begin
            if (r_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL r_unexpected: got data %h, required no beat", r_data);
            end else begin
               re_m = r_q[0];
               check("r_data", r_data, re_m.data);
               check("r_resp", 64'(r_resp), 64'(re_m.resp));
               check("r_last", 64'(r_last), 64'(re_m.last));
               check("r_id", 64'(r_id), 64'(re_m.id));
               if (r_ready) r_q.delete(0);
            end
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   // ---------------- test sequence ----------------
   initial begin
      int n;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_w_ready", 64'(w_ready), 0);
      check("rst_b_valid", 64'(b_valid), 0);
      check("rst_r_valid", 64'(r_valid), 0);
      check("rst_r_data", r_data, 0);
      check("rst_ids_resps", 64'({b_id, r_id, b_resp, r_resp, r_last}), 0);
      check("rst_user", 64'({b_user, r_user}), 0);
      @(posedge clk); #1;
      rst_n = 1;
      @(posedge clk); #1;

      // Make the whole memory known to the model.
      fill(256, 8'hFF);
      do_write(32'h0, 8'd255, 3'd3, 2'd1, 3'd1, -1, 0);

      // Single write / read back.
      wbuf[0] = 64'h1122334455667788; sbuf[0] = 8'hFF;
      do_write(32'h10, 8'd0, 3'd3, 2'd1, 3'd5, -1, 0);
      do_read(32'h10, 8'd0, 3'd3, 2'd1, 3'd6);

      // Burst write, partial-strobe overwrite, burst read.
      for (int i = 0; i < 4; i++) begin wbuf[i] = 64'(i); sbuf[i] = 8'hFF; end
      do_write(32'h0, 8'd3, 3'd3, 2'd1, 3'd2, -1, 0);
      wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF; sbuf[0] = 8'h0F;
      do_write(32'h8, 8'd0, 3'd3, 2'd1, 3'd2, -1, 0);
      do_read(32'h0, 8'd3, 3'd3, 2'd1, 3'd3);

      // Burst running off the end of memory.
      fill(2, 8'hFF);
      do_write(32'h7F8, 8'd1, 3'd3, 2'd1, 3'd4, -1, 0);
      do_read(32'h7F8, 8'd1, 3'd3, 2'd1, 3'd4);

      // WRAP and oversize bursts: errors, memory untouched.
      fill(2, 8'hFF);
      do_write(32'h40, 8'd1, 3'd3, 2'd2, 3'd1, -1, 0);
      fill(2, 8'hFF);
      do_write(32'h40, 8'd1, 3'd4, 2'd1, 3'd1, -1, 0);
      do_read(32'h40, 8'd1, 3'd3, 2'd1, 3'd0);
      do_read(32'h40, 8'd1, 3'd3, 2'd3, 3'd7);

      // FIXED read repeats one word.
      do_read(32'h18, 8'd2, 3'd3, 2'd0, 3'd2);

      // Simultaneous AW/AR: grants alternate starting with the write.
      grant_log = "";
      fork
         for (int k = 0; k < 3; k++) begin
            fill(2, 8'hFF);
            do_write(32'h400 + 32'(k) * 32'h40, 8'd1, 3'd3, 2'd1, 3'(k), -1, 0);
         end
         for (int k = 0; k < 3; k++) do_read(32'h20 + 32'(k) * 32'h8, 8'd1, 3'd3, 2'd1, 3'(k + 4));
      join
      checks++;
      if (grant_log != "WRWRWR") begin
         errors++;
         $display("FAIL grant_order: got %s required WRWRWR", grant_log);
      end

      // Master stalls R for five cycles mid-burst.
      fork
         do_read(32'h30, 8'd3, 3'd3, 2'd1, 3'd3);
         begin
            n = 0;
            while (!r_valid && n < TMO) begin @(negedge clk); n++; end
            rr_mode = 2;
            repeat (6) @(posedge clk);
            rr_mode = 0;
         end
      join

      // Early w_last on beat 1 of a 4-beat burst.
      fill(4, 8'hFF);
      do_write(32'h200, 8'd3, 3'd3, 2'd1, 3'd6, 1, 0);
      do_read(32'h200, 8'd3, 3'd3, 2'd1, 3'd6);

      // Reset in the middle of a read burst.
      mon_en = 0;
      ar_addr = 32'h0; ar_len = 8'd7; ar_size = 3'd3; ar_burst = 2'd1; ar_id = 3'd5; ar_valid = 1;
      n = 0;
      while (!ar_ready && n < TMO) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      ar_valid = 0;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 0;
      #1;
      check("rst_mid_r_valid", 64'(r_valid), 0);
      check("rst_mid_r_data", r_data, 0);
      check("rst_mid_r_last", 64'(r_last), 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1;
      mon_en = 1;
      @(negedge clk);
      check("post_rst_r_valid", 64'(r_valid), 0);
      @(posedge clk); #1;
      do_read(32'h8, 8'd2, 3'd3, 2'd1, 3'd2);
      fill(1, 8'hA5);
      do_write(32'h88, 8'd0, 3'd3, 2'd1, 3'd3, -1, 0);
      do_read(32'h88, 8'd0, 3'd3, 2'd1, 3'd3);

      // Randomised traffic.
      rr_mode = 1;
      for (int t = 0; t < 80; t++) begin
         logic [31:0] a;
         logic [7:0]  len;
         logic [2:0]  sz;
         logic [1:0]  bu;
         int          sel;
         a   = $urandom_range(0, 32'h830);
         len = 8'($urandom_range(0, 7));
         sel = $urandom_range(0, 9);
         sz  = (sel < 7) ? 3'd3 : 3'($urandom_range(0, 4));
         sel = $urandom_range(0, 19);
         bu  = (sel < 4) ? 2'd0 : (sel < 17) ? 2'd1 : 2'($urandom_range(2, 3));
         if ($urandom_range(0, 1) == 0) begin
            for (int i = 0; i <= int'(len); i++) begin
               wbuf[i] = {$urandom, $urandom};
               sbuf[i] = 8'($urandom);
            end
            do_write(a, len, sz, bu, 3'($urandom), ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : -1, 1);
         end else begin
            do_read(a, len, sz, bu, 3'($urandom));
         end
      end

      // A final full read-back of the model.
      rr_mode = 0;
      do_read(32'h0, 8'd255, 3'd3, 2'd1, 3'd0);

      n = 0;
      while ((b_q.size() != 0 || r_q.size() != 0) && n < TMO) begin @(negedge clk); n++; end
      check("queues_drained", 64'(b_q.size() + r_q.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
